pio_cpl_scheduler: RTL and testbench
====================================

# pio_cpl_scheduler

Completion scheduler between the PIO RX engine's two BAR read paths and the single PIO TX completion engine. Each BAR read request's descriptor (tc/attr/len/rid/tag/be/addr/at) is captured when its `barN_rd` strobe fires. The descriptor is paired in order with the 32-bit read data returned by that BAR's register file. The resulting completions are presented one at a time to the TX engine under a valid/ready handshake, with round-robin arbitration between BAR0 and BAR1.

## Interface
- `FIFO_DEPTH`, 4: descriptor/data entries per BAR; power of two, ≥2.
- `pcie_clk`  in  1  PCIe user clock (125 MHz).
- `pcie_rst_n`  in  1  asynchronous, active-low reset.
- `barN_rd` (N=0,1)  in  1  one-cycle read strobe from the RX engine; descriptor fields are valid in the same cycle.
- `barN_req_tc`  in  3  traffic class.
- `barN_req_attr`  in  3  attributes.
- `barN_req_len`  in  11  length in DW.
- `barN_req_rid`  in  16  requester ID.
- `barN_req_tag`  in  8  tag.
- `barN_req_be`  in  8  byte enables.
- `barN_req_addr`  in  16  byte address.
- `barN_req_at`  in  2  address translation.
- `barN_rd_valid`  in  1  one-cycle strobe from the register file: read data returned.
- `barN_rd_data`  in  32  read data.
- `barN_full`  out  1  descriptor FIFO of BAR N holds `FIFO_DEPTH` entries.
- `cpl_valid`  out  1  completion presented to the TX engine.
- `cpl_ready`  in  1  TX engine accepts the presented completion.
- `cpl_bar`  out  1  source BAR of the presented completion.
- `cpl_tc`  out  3  completion traffic class.
- `cpl_attr`  out  3  completion attributes.
- `cpl_len`  out  11  completion length.
- `cpl_rid`  out  16  completion requester ID.
- `cpl_tag`  out  8  completion tag.
- `cpl_be`  out  8  completion byte enables.
- `cpl_addr`  out  16  completion address.
- `cpl_at`  out  2  completion address translation.
- `cpl_data`  out  32  completion data.
- `err_ovf`  out  2  sticky per BAR: `barN_rd` arrived while `barN_full`.
- `err_orphan`  out  2  sticky per BAR: `barN_rd_valid` arrived with no descriptor awaiting data.

## Operation
- Per BAR: a descriptor FIFO of 67 bits × `FIFO_DEPTH`, a data FIFO of 32 × `FIFO_DEPTH`, and an awaiting-data counter `pend` of log2(`FIFO_DEPTH`)+1 bits.
- Descriptor push on `barN_rd` only when the descriptor FIFO is not full at that cycle. A pop in the same cycle does not free space for this push. On a refused push, set `err_ovf[N]` and drop the descriptor.
- Data push on `barN_rd_valid` only when `pend`>0; then `pend` decrements. Otherwise set `err_orphan[N]` and drop the data.
- `pend` increments on each accepted descriptor push. A simultaneous increment and decrement nets to zero.
- BAR N is ready when its data FIFO is non-empty. Descriptors and data pair strictly in FIFO order.
- State machine:
  - `IDLE`: if any BAR is ready, grant one BAR. Load all `cpl_*` registers from the heads of the granted BAR's FIFOs, pop both heads, set `cpl_valid`, and go to `SEND`.
  - `SEND`: hold `cpl_valid` and all `cpl_*` fields stable. When `cpl_ready`=1, clear `cpl_valid` and return to `IDLE`.
- Round-robin arbitration: a pointer `last` records the last granted BAR. When both BARs are ready, grant the BAR ≠ `last`. When only one is ready, grant it. Reset value of `last`=1, so BAR0 wins the first tie.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy counts range 0..`FIFO_DEPTH`.
- `err_*` bits clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous release by `pcie_clk`) forces:
  - `cpl_valid`=0, all `cpl_*` fields=0, `cpl_bar`=0;
  - `barN_full`=0, `err_ovf`=0, `err_orphan`=0;
  - all FIFOs empty, `pend`=0, `last`=1, state=`IDLE`.
- Reset mid-`SEND` drops the pending completion without handshake.
- Latency: data push at clock edge E → `cpl_valid`=1 after edge E+1, if the scheduler is idle.
- Throughput: at most one completion per 2 cycles. The `IDLE` bubble cycle follows every accepted handshake.
- Handshake: transfer occurs at an edge where `cpl_valid`=1 and `cpl_ready`=1. `cpl_ready` while `cpl_valid`=0 is ignored. Fields must not change while `cpl_valid`=1 and `cpl_ready`=0.
- `barN_full` is registered and reflects occupancy after the current edge.
- Simultaneous pushes on both BARs in one cycle are independent. Simultaneous push and pop on one BAR are both honoured, except the full-refusal rule above.

## Test plan
- Single read: `bar0_rd` with tag=0x12 and addr=0x0040, then `bar0_rd_valid` 3 cycles later with data=0xDEADBEEF → one completion: `cpl_bar`=0, `cpl_tag`=0x12, `cpl_addr`=0x0040, `cpl_data`=0xDEADBEEF, `cpl_valid` rising 2 edges after the data strobe.
- Backpressure: hold `cpl_ready`=0 for 10 cycles → `cpl_valid` stays 1 with all fields constant. Set `cpl_ready`=1 → `cpl_valid`=0 next cycle.
- Arbitration: both BARs ready with 2 entries each and `cpl_ready` tied 1 → grant order BAR0, BAR1, BAR0, BAR1 with tags preserved per BAR.
- Overflow: 5 `bar1_rd` strobes with no data returned (`FIFO_DEPTH`=4) → `bar1_full`=1 after the 4th, `err_ovf`=2'b10. Returning 4 data words yields exactly the first 4 tags in order.
- Orphan: `bar0_rd_valid` with no outstanding request → `err_orphan`=2'b01, no completion emitted.
- Reset mid-`SEND`: assert `pcie_rst_n`=0 while `cpl_valid`=1 → `cpl_valid`=0 immediately (asynchronous). After release, an empty scheduler emits nothing.

Source files
------------

// File: rtl/pio_cpl_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pio_cpl_scheduler
// Brief    : Pairs BAR0/BAR1 read descriptors with returned read data and
//            presents completions to the PIO TX engine, round-robin arbitrated.
// Revision : 1.0 - initial release
// ============================================================================
module pio_cpl_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst_n,

    input  logic        bar0_rd,
    input  logic [2:0]  bar0_req_tc,
    input  logic [2:0]  bar0_req_attr,
    input  logic [10:0] bar0_req_len,
    input  logic [15:0] bar0_req_rid,
    input  logic [7:0]  bar0_req_tag,
    input  logic [7:0]  bar0_req_be,
    input  logic [15:0] bar0_req_addr,
    input  logic [1:0]  bar0_req_at,
    input  logic        bar0_rd_valid,
    input  logic [31:0] bar0_rd_data,
    output logic        bar0_full,

    input  logic        bar1_rd,
    input  logic [2:0]  bar1_req_tc,
    input  logic [2:0]  bar1_req_attr,
    input  logic [10:0] bar1_req_len,
    input  logic [15:0] bar1_req_rid,
    input  logic [7:0]  bar1_req_tag,
    input  logic [7:0]  bar1_req_be,
    input  logic [15:0] bar1_req_addr,
    input  logic [1:0]  bar1_req_at,
    input  logic        bar1_rd_valid,
    input  logic [31:0] bar1_rd_data,
    output logic        bar1_full,

    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic        cpl_bar,
    output logic [2:0]  cpl_tc,
    output logic [2:0]  cpl_attr,
    output logic [10:0] cpl_len,
    output logic [15:0] cpl_rid,
    output logic [7:0]  cpl_tag,
    output logic [7:0]  cpl_be,
    output logic [15:0] cpl_addr,
    output logic [1:0]  cpl_at,
    output logic [31:0] cpl_data,

    output logic [1:0]  err_ovf,
    output logic [1:0]  err_orphan
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = 67;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [1:0]      w_rd;
    logic [1:0]      w_rd_valid;
    logic [c_DW-1:0] w_desc_in   [2];
    logic [31:0]     w_data_in   [2];
    logic [c_DW-1:0] w_desc_head [2];
    logic [31:0]     w_data_head [2];
    logic [1:0]      w_ready;
    logic [1:0]      w_pop;
    logic [1:0]      w_full;
    logic [1:0]      w_ovf;
    logic [1:0]      w_orphan;
    logic            w_go;
    logic            w_grant;

    assign w_rd       = {bar1_rd, bar0_rd};
    assign w_rd_valid = {bar1_rd_valid, bar0_rd_valid};
    assign w_desc_in[0] = {bar0_req_tc, bar0_req_attr, bar0_req_len, bar0_req_rid,
                           bar0_req_tag, bar0_req_be, bar0_req_addr, bar0_req_at};
    assign w_desc_in[1] = {bar1_req_tc, bar1_req_attr, bar1_req_len, bar1_req_rid,
                           bar1_req_tag, bar1_req_be, bar1_req_addr, bar1_req_at};
    assign w_data_in[0] = bar0_rd_data;
    assign w_data_in[1] = bar1_rd_data;

    for (genvar i = 0; i < 2; i++) begin : g_bar
        logic [c_DW-1:0] r_dmem [FIFO_DEPTH];
        logic [31:0]     r_xmem [FIFO_DEPTH];
        logic [c_AW-1:0] r_dwp, r_drp, r_xwp, r_xrp;
        logic [c_CW-1:0] r_dcnt, r_xcnt, r_pend;
        logic            r_full, r_ovf, r_orphan;
        logic            w_dpush, w_xpush;
        logic [c_CW-1:0] w_dcnt_nxt;

        // Full is sampled before this edge's pop, so a pop never makes room for a same-cycle push.
        assign w_dpush    = w_rd[i] & ~r_full;
        assign w_xpush    = w_rd_valid[i] & (r_pend != '0);
        assign w_dcnt_nxt = r_dcnt + c_CW'(w_dpush) - c_CW'(w_pop[i]);

        always_ff @(posedge pcie_clk) begin
            if (w_dpush) r_dmem[r_dwp] <= w_desc_in[i];
            if (w_xpush) r_xmem[r_xwp] <= w_data_in[i];
        end

        always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
            if (!pcie_rst_n) begin
                r_dwp    <= '0;
                r_drp    <= '0;
                r_xwp    <= '0;
                r_xrp    <= '0;
                r_dcnt   <= '0;
                r_xcnt   <= '0;
                r_pend   <= '0;
                r_full   <= 1'b0;
                r_ovf    <= 1'b0;
                r_orphan <= 1'b0;
            end else begin
                if (w_dpush) r_dwp <= r_dwp + 1'b1;
                if (w_xpush) r_xwp <= r_xwp + 1'b1;
                if (w_pop[i]) begin
                    r_drp <= r_drp + 1'b1;
                    r_xrp <= r_xrp + 1'b1;
                end
                r_dcnt <= w_dcnt_nxt;
                r_full <= (w_dcnt_nxt == c_FULL);
                r_xcnt <= r_xcnt + c_CW'(w_xpush) - c_CW'(w_pop[i]);
                r_pend <= r_pend + c_CW'(w_dpush) - c_CW'(w_xpush);
                if (w_rd[i] && r_full)             r_ovf    <= 1'b1;
                if (w_rd_valid[i] && r_pend == '0) r_orphan <= 1'b1;
            end
        end

        assign w_desc_head[i] = r_dmem[r_drp];
        assign w_data_head[i] = r_xmem[r_xrp];
        assign w_ready[i]     = (r_xcnt != '0);
        assign w_full[i]      = r_full;
        assign w_ovf[i]       = r_ovf;
        assign w_orphan[i]    = r_orphan;
    end

    state_t          r_state;
    logic            r_last;
    logic            r_cpl_valid;
    logic            r_cpl_bar;
    logic [c_DW-1:0] r_cpl_desc;
    logic [31:0]     r_cpl_data;

    always_comb begin
        w_grant = (w_ready == 2'b11) ? ~r_last : w_ready[1];
        w_go    = (r_state == S_IDLE) && (w_ready != 2'b00);
        w_pop   = w_go ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_cpl_valid <= 1'b0;
            r_cpl_bar   <= 1'b0;
            r_cpl_desc  <= '0;
            r_cpl_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cpl_desc  <= w_desc_head[w_grant];
                        r_cpl_data  <= w_data_head[w_grant];
                        r_cpl_bar   <= w_grant;
                        r_last      <= w_grant;
                        r_cpl_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cpl_ready) begin
                        r_cpl_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpl_valid = r_cpl_valid;
    assign cpl_bar   = r_cpl_bar;
    assign {cpl_tc, cpl_attr, cpl_len, cpl_rid, cpl_tag, cpl_be, cpl_addr, cpl_at} = r_cpl_desc;
    assign cpl_data  = r_cpl_data;
    assign bar0_full  = w_full[0];
    assign bar1_full  = w_full[1];
    assign err_ovf    = w_ovf;
    assign err_orphan = w_orphan;

endmodule
`default_nettype wire

// File: tb/tb_pio_cpl_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_cpl_scheduler
// Brief    : Directed bench with a queue-based completion model for pio_cpl_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_cpl_scheduler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [10:0] len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [7:0]  be;
        logic [15:0] addr;
        logic [1:0]  at;
    } desc_t;

    logic        pcie_clk   = 1'b0;
    logic        pcie_rst_n = 1'b1;
    logic [1:0]  rd  = 2'b00;
    logic [1:0]  rdv = 2'b00;
    desc_t       din [2];
    logic [31:0] dat [2];
    logic        cpl_ready = 1'b0;

    logic        bar0_full, bar1_full, cpl_valid, cpl_bar;
    logic [2:0]  cpl_tc, cpl_attr;
    logic [10:0] cpl_len;
    logic [15:0] cpl_rid, cpl_addr;
    logic [7:0]  cpl_tag, cpl_be;
    logic [1:0]  cpl_at, err_ovf, err_orphan;
    logic [31:0] cpl_data;

    int checks = 0;
    int errors = 0;

    pio_cpl_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
        .bar0_rd(rd[0]), .bar0_req_tc(din[0].tc), .bar0_req_attr(din[0].attr),
        .bar0_req_len(din[0].len), .bar0_req_rid(din[0].rid), .bar0_req_tag(din[0].tag),
        .bar0_req_be(din[0].be), .bar0_req_addr(din[0].addr), .bar0_req_at(din[0].at),
        .bar0_rd_valid(rdv[0]), .bar0_rd_data(dat[0]), .bar0_full(bar0_full),
        .bar1_rd(rd[1]), .bar1_req_tc(din[1].tc), .bar1_req_attr(din[1].attr),
        .bar1_req_len(din[1].len), .bar1_req_rid(din[1].rid), .bar1_req_tag(din[1].tag),
        .bar1_req_be(din[1].be), .bar1_req_addr(din[1].addr), .bar1_req_at(din[1].at),
        .bar1_rd_valid(rdv[1]), .bar1_rd_data(dat[1]), .bar1_full(bar1_full),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_bar(cpl_bar),
        .cpl_tc(cpl_tc), .cpl_attr(cpl_attr), .cpl_len(cpl_len), .cpl_rid(cpl_rid),
        .cpl_tag(cpl_tag), .cpl_be(cpl_be), .cpl_addr(cpl_addr), .cpl_at(cpl_at),
        .cpl_data(cpl_data), .err_ovf(err_ovf), .err_orphan(err_orphan)
    );

    always #4 pcie_clk = ~pcie_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: accepted descriptors and returned data per BAR as queues, one
    // completion slot, and the last-granted BAR.
    desc_t       mdq [2][$];
    logic [31:0] mxq [2][$];
    int          mpend [2];
    bit          mvalid, mbar, mlast;
    desc_t       mdesc;
    logic [31:0] mdata;
    bit   [1:0]  movf, morph;

    always @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            for (int b = 0; b < 2; b++) begin
                mdq[b].delete();
                mxq[b].delete();
                mpend[b] = 0;
            end
            mvalid = 0; mbar = 0; mlast = 1; mdesc = '0; mdata = '0;
            movf = 0; morph = 0;
        end else begin : step
            bit [1:0] rdy;
            bit [1:0] fpre;
            int g;
            for (int b = 0; b < 2; b++) begin
                rdy[b]  = (mxq[b].size() != 0);
                fpre[b] = (mdq[b].size() == DEPTH);
            end
            if (!mvalid) begin
                if (rdy != 2'b00) begin
                    g = (rdy == 2'b11) ? (mlast ? 0 : 1) : (rdy[1] ? 1 : 0);
                    mdesc  = mdq[g].pop_front();
                    mdata  = mxq[g].pop_front();
                    mbar   = (g == 1);
                    mlast  = (g == 1);
                    mvalid = 1;
                end
            end else if (cpl_ready) begin
                mvalid = 0;
            end
            for (int b = 0; b < 2; b++) begin
                bit acc;
                acc = 0;
                if (rd[b]) begin
                    if (!fpre[b]) begin
                        mdq[b].push_back(din[b]);
                        acc = 1;
                    end else begin
                        movf[b] = 1;
                    end
                end
                if (rdv[b]) begin
                    if (mpend[b] > 0) begin
                        mxq[b].push_back(dat[b]);
                        mpend[b]--;
                    end else begin
                        morph[b] = 1;
                    end
                end
                if (acc) mpend[b]++;
            end
        end
    end

    always @(negedge pcie_clk) begin
        chk("cpl_valid", cpl_valid, mvalid);
        if (mvalid) begin
            chk("cpl_bar", cpl_bar, mbar);
            chk("cpl_desc", {cpl_tc, cpl_attr, cpl_len, cpl_rid, cpl_tag, cpl_be, cpl_addr, cpl_at}, mdesc);
            chk("cpl_data", cpl_data, mdata);
        end
        chk("bar0_full", bar0_full, mdq[0].size() == DEPTH);
        chk("bar1_full", bar1_full, mdq[1].size() == DEPTH);
        chk("err_ovf", err_ovf, movf);
        chk("err_orphan", err_orphan, morph);
    end

    logic        log_bar  [$];
    logic [7:0]  log_tag  [$];
    logic [31:0] log_data [$];

    always @(posedge pcie_clk) begin
        if (pcie_rst_n && cpl_valid && cpl_ready) begin
            log_bar.push_back(cpl_bar);
            log_tag.push_back(cpl_tag);
            log_data.push_back(cpl_data);
        end
    end

    task automatic clear_log();
        log_bar.delete();
        log_tag.delete();
        log_data.delete();
    endtask

    task automatic set_desc(input int b, input logic [7:0] tag, input logic [15:0] addr);
        din[b].tc   = tag[2:0];
        din[b].attr = tag[5:3];
        din[b].len  = {3'b000, tag} + 11'd1;
        din[b].rid  = {tag, ~tag};
        din[b].tag  = tag;
        din[b].be   = tag ^ 8'h5A;
        din[b].addr = addr;
        din[b].at   = tag[7:6];
    endtask

    task automatic send_rd(input int b, input logic [7:0] tag, input logic [15:0] addr);
        set_desc(b, tag, addr);
        rd[b] = 1'b1;
        @(negedge pcie_clk);
        rd[b] = 1'b0;
    endtask

    task automatic send_data(input int b, input logic [31:0] d);
        dat[b] = d;
        rdv[b] = 1'b1;
        @(negedge pcie_clk);
        rdv[b] = 1'b0;
    endtask

    task automatic do_reset();
        #2 pcie_rst_n = 1'b0;
        repeat (2) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        @(negedge pcie_clk);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (cpl_valid !== 1'b1 && n < budget) begin
            @(negedge pcie_clk);
            n++;
        end
        chk("wait_valid", cpl_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++) begin
            din[b] = '0;
            dat[b] = '0;
        end
        #1 pcie_rst_n = 1'b0;
        repeat (2) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        @(negedge pcie_clk);
        chk("rst_valid", cpl_valid, 1'b0);
        chk("rst_bar", cpl_bar, 1'b0);
        chk("rst_tag", cpl_tag, 8'h00);
        chk("rst_data", cpl_data, 32'h0);
        chk("rst_full", {bar1_full, bar0_full}, 2'b00);
        chk("rst_err", {err_ovf, err_orphan}, 4'h0);

        // Single read with latency and backpressure
        send_rd(0, 8'h12, 16'h0040);
        repeat (2) @(negedge pcie_clk);
        send_data(0, 32'hDEADBEEF);
        chk("lat_e0", cpl_valid, 1'b0);
        @(negedge pcie_clk);
        chk("lat_e1", cpl_valid, 1'b1);
        chk("single_bar", cpl_bar, 1'b0);
        chk("single_tag", cpl_tag, 8'h12);
        chk("single_addr", cpl_addr, 16'h0040);
        chk("single_data", cpl_data, 32'hDEADBEEF);
        repeat (10) @(negedge pcie_clk);
        chk("bp_valid", cpl_valid, 1'b1);
        chk("bp_tag", cpl_tag, 8'h12);
        cpl_ready = 1'b1;
        @(negedge pcie_clk);
        cpl_ready = 1'b0;
        chk("bp_release", cpl_valid, 1'b0);
        chk("single_count", log_tag.size(), 1);

        // Round-robin between two loaded BARs
        do_reset();
        clear_log();
        cpl_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_desc(0, 8'hA0 + 8'(k), 16'h0100 + 16'(k * 4));
            set_desc(1, 8'hB0 + 8'(k), 16'h0200 + 16'(k * 4));
            rd = 2'b11;
            @(negedge pcie_clk);
        end
        rd = 2'b00;
        for (int k = 0; k < 2; k++) begin
            dat[0] = 32'hA000_0000 + 32'(k);
            dat[1] = 32'hB000_0000 + 32'(k);
            rdv = 2'b11;
            @(negedge pcie_clk);
        end
        rdv = 2'b00;
        repeat (10) @(negedge pcie_clk);
        chk("arb_count", log_tag.size(), 4);
        begin
            logic [7:0] exp_tag [4];
            logic       exp_bar [4];
            exp_tag = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
            exp_bar = '{1'b0, 1'b1, 1'b0, 1'b1};
            for (int k = 0; k < 4 && k < log_tag.size(); k++) begin
                chk("arb_bar", log_bar[k], exp_bar[k]);
                chk("arb_tag", log_tag[k], exp_tag[k]);
            end
        end

        // Overflow on BAR1
        clear_log();
        for (int k = 0; k < 5; k++) begin
            send_rd(1, 8'hC0 + 8'(k), 16'h0300 + 16'(k * 4));
            if (k == 2) chk("ovf_full3", bar1_full, 1'b0);
            if (k == 3) chk("ovf_full4", bar1_full, 1'b1);
        end
        chk("ovf_err", err_ovf, 2'b10);
        for (int k = 0; k < 4; k++) send_data(1, 32'h0000_1000 + 32'(k));
        repeat (12) @(negedge pcie_clk);
        chk("ovf_count", log_tag.size(), 4);
        for (int k = 0; k < 4 && k < log_tag.size(); k++) begin
            chk("ovf_tag", log_tag[k], 8'hC0 + 8'(k));
            chk("ovf_data", log_data[k], 32'h0000_1000 + 32'(k));
        end
        chk("ovf_full_clr", bar1_full, 1'b0);

        // Orphan data on BAR0
        clear_log();
        send_data(0, 32'h0000_0BAD);
        repeat (5) @(negedge pcie_clk);
        chk("orphan_err", err_orphan, 2'b01);
        chk("orphan_none", log_tag.size(), 0);

        // Reset while a completion is presented
        cpl_ready = 1'b0;
        send_rd(0, 8'h55, 16'h0080);
        send_data(0, 32'h5555_5555);
        wait_valid(10);
        #2 pcie_rst_n = 1'b0;
        #1 chk("async_rst_valid", cpl_valid, 1'b0);
        chk("async_rst_err", {err_ovf, err_orphan}, 4'h0);
        repeat (2) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        clear_log();
        cpl_ready = 1'b1;
        repeat (8) @(negedge pcie_clk);
        chk("post_rst_none", log_tag.size(), 0);
        chk("post_rst_valid", cpl_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
